// File: rtl/ifq_fetch_ctrl.sv
// Instruction fetch controller: walks the PC through 16-byte ROM lines and
// enqueues the usable words of each line into a circular instruction queue.
module ifq_fetch_ctrl #(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic [31:0]              rom_addr,
  input  logic [127:0]             rom_data,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     inst_valid,
  output logic [31:0]              inst,
  output logic [31:0]              inst_pc,
  input  logic                     inst_ready,
  output logic [$clog2(DEPTH):0]   ifq_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   pc_reg, pc_next;
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;

  logic [31:0] inst_mem [DEPTH];
  logic [31:0] pc_mem   [DEPTH];

  logic [1:0]    start_word;
  logic [2:0]    fetch_n;
  logic [CW-1:0] space;
  logic          fetch;
  logic          pop;
  logic [3:0]    word_en;
  logic [AW-1:0] slot [4];
  logic          unused_bits;

  assign start_word = pc_reg[3:2];
  assign fetch_n    = 3'd4 - {1'b0, start_word};
  // Space is judged on the start-of-cycle count; a same-cycle pop does not help.
  assign space      = CW'(DEPTH) - count_reg;
  assign fetch      = !redirect_valid && (space >= CW'(fetch_n));
  assign inst_valid = (count_reg != '0) && !redirect_valid;
  assign pop        = inst_valid && inst_ready;

  assign rom_addr    = {pc_reg[31:4], 4'b0000};
  assign inst        = inst_mem[rd_ptr_reg];
  assign inst_pc     = pc_mem[rd_ptr_reg];
  assign ifq_count   = count_reg;
  assign unused_bits = ^{redirect_pc[1:0], pc_reg[1:0]};

  // Word gi of the line lands gi - start_word slots past the write pointer.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_word
      assign word_en[gi] = fetch && (2'(gi) >= start_word);
      assign slot[gi]    = wr_ptr_reg + AW'(2'(gi) - start_word);
    end
  endgenerate

  always_comb begin
    pc_next     = pc_reg;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (redirect_valid) begin
      pc_next     = {redirect_pc[31:2], 2'b00};
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (fetch) begin
        pc_next     = {pc_reg[31:4] + 28'd1, 4'b0000};
        wr_ptr_next = wr_ptr_reg + AW'(fetch_n);
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + AW'(1);
      end
      count_next = count_reg + (fetch ? CW'(fetch_n) : CW'(0)) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_reg     <= {RESET_PC[31:2], 2'b00};
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      pc_reg     <= pc_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Queue storage carries no reset; only entries below count are ever read.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rst_n && word_en[k]) begin
        inst_mem[slot[k]] <= rom_data[32*k +: 32];
        pc_mem[slot[k]]   <= {pc_reg[31:4], 2'(k), 2'b00};
      end
    end
  end

endmodule

// File: tb/tb_ifq_fetch_ctrl.sv
// Directed bench for ifq_fetch_ctrl: vector table for backpressure and space
// threshold, hand sequences for streaming, redirects and mid-stream reset.
module tb_ifq_fetch_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  rom_addr;
  logic [127:0] rom_data;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic         inst_valid;
  logic [31:0]  inst;
  logic [31:0]  inst_pc;
  logic         inst_ready;
  logic [3:0]   ifq_count;

  int checks = 0;
  int errors = 0;

  ifq_fetch_ctrl #(.DEPTH(8), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_data(rom_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_ready(inst_ready), .ifq_count(ifq_count)
  );

  always #5 clk = ~clk;

  // ROM model: the word at byte address A holds 0x1000_0000 + A/4.
  always_comb begin
    rom_data = '0;
    for (int k = 0; k < 4; k++)
      rom_data[32*k +: 32] = 32'h1000_0000 + (rom_addr >> 2) + 32'(k);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  // Apply inputs at the falling edge, then settle before the caller checks.
  task automatic drive(input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy);
    @(negedge clk);
    rst_n = rst; redirect_valid = rv; redirect_pc = rpc; inst_ready = rdy;
    #1;
  endtask

  typedef struct {
    logic        rdy;
    logic        valid;
    int          word;
    logic [3:0]  count;
    logic [31:0] rom;
  } vec_t;

  vec_t vt [14];

  initial begin
    vt[0]  = '{1'b0, 1'b0, 0, 4'd0, 32'h00};
    vt[1]  = '{1'b0, 1'b1, 0, 4'd4, 32'h10};
    vt[2]  = '{1'b0, 1'b1, 0, 4'd8, 32'h20};
    vt[3]  = '{1'b0, 1'b1, 0, 4'd8, 32'h20};
    vt[4]  = '{1'b1, 1'b1, 0, 4'd8, 32'h20};
    vt[5]  = '{1'b1, 1'b1, 1, 4'd7, 32'h20};
    vt[6]  = '{1'b1, 1'b1, 2, 4'd6, 32'h20};
    vt[7]  = '{1'b1, 1'b1, 3, 4'd5, 32'h20};
    vt[8]  = '{1'b1, 1'b1, 4, 4'd4, 32'h20};
    vt[9]  = '{1'b1, 1'b1, 5, 4'd7, 32'h30};
    vt[10] = '{1'b1, 1'b1, 6, 4'd6, 32'h30};
    vt[11] = '{1'b1, 1'b1, 7, 4'd5, 32'h30};
    vt[12] = '{1'b1, 1'b1, 8, 4'd4, 32'h30};
    vt[13] = '{1'b1, 1'b1, 9, 4'd7, 32'h40};

    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;

    // Backpressure then space threshold, one table row per cycle.
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    for (int i = 0; i < 14; i++) begin
      drive(1, 0, 0, vt[i].rdy);
      chk($sformatf("vec%0d count", i), 32'(ifq_count), 32'(vt[i].count));
      chk($sformatf("vec%0d rom_addr", i), rom_addr, vt[i].rom);
      chk($sformatf("vec%0d valid", i), 32'(inst_valid), 32'(vt[i].valid));
      if (vt[i].valid) begin
        chk($sformatf("vec%0d inst", i), inst, 32'h1000_0000 + 32'(vt[i].word));
        chk($sformatf("vec%0d inst_pc", i), inst_pc, 32'(vt[i].word) * 4);
      end
    end

    // Streaming from reset with inst_ready held high.
    drive(0, 0, 0, 1);
    drive(1, 0, 0, 1);
    chk("stream c0 valid", 32'(inst_valid), 32'd0);
    chk("stream c0 rom_addr", rom_addr, 32'h0);
    for (int i = 0; i < 40; i++) begin
      drive(1, 0, 0, 1);
      chk($sformatf("stream%0d valid", i), 32'(inst_valid), 32'd1);
      chk($sformatf("stream%0d inst", i), inst, 32'h1000_0000 + 32'(i));
      chk($sformatf("stream%0d inst_pc", i), inst_pc, 32'(i) * 4);
      chk($sformatf("stream%0d count<=8", i), 32'(ifq_count <= 4'd8), 32'd1);
    end

    // Unaligned redirect to 0x3B while the queue is non-empty.
    drive(1, 1, 32'h3B, 1);
    chk("redir valid", 32'(inst_valid), 32'd0);
    drive(1, 0, 0, 0);
    chk("redir t1 rom_addr", rom_addr, 32'h30);
    chk("redir t1 count", 32'(ifq_count), 32'd0);
    chk("redir t1 valid", 32'(inst_valid), 32'd0);
    drive(1, 0, 0, 1);
    chk("redir t2 rom_addr", rom_addr, 32'h40);
    chk("redir t2 count", 32'(ifq_count), 32'd2);
    chk("redir t2 inst_pc", inst_pc, 32'h38);
    chk("redir t2 inst", inst, 32'h1000_000E);
    drive(1, 0, 0, 1);
    chk("redir t3 inst_pc", inst_pc, 32'h3C);
    chk("redir t3 count", 32'(ifq_count), 32'd5);
    drive(1, 0, 0, 1);
    chk("redir t4 inst_pc", inst_pc, 32'h40);

    // Fill to 8 at 0x100, then redirect with inst_ready high.
    drive(1, 1, 32'h100, 0);
    drive(1, 0, 0, 0);
    chk("fill rom_addr", rom_addr, 32'h100);
    drive(1, 0, 0, 0);
    chk("fill count4", 32'(ifq_count), 32'd4);
    drive(1, 1, 32'h200, 1);
    chk("full count", 32'(ifq_count), 32'd8);
    chk("full redir valid", 32'(inst_valid), 32'd0);
    drive(1, 0, 0, 1);
    chk("full t1 count", 32'(ifq_count), 32'd0);
    chk("full t1 valid", 32'(inst_valid), 32'd0);
    chk("full t1 rom_addr", rom_addr, 32'h200);
    drive(1, 0, 0, 1);
    chk("full t2 count", 32'(ifq_count), 32'd4);
    chk("full t2 inst_pc", inst_pc, 32'h200);
    drive(1, 0, 0, 1);
    chk("full t3 inst_pc", inst_pc, 32'h204);
    chk("full t3 count", 32'(ifq_count), 32'd7);

    // Build count = 5, pc = 0x80, then reset for one cycle.
    drive(1, 1, 32'h6C, 0);
    drive(1, 0, 0, 0);
    chk("pre rom 0x60", rom_addr, 32'h60);
    drive(1, 0, 0, 0);
    chk("pre count1", 32'(ifq_count), 32'd1);
    drive(0, 1, 32'h500, 1);
    chk("pre count5", 32'(ifq_count), 32'd5);
    chk("pre rom 0x80", rom_addr, 32'h80);
    drive(1, 0, 0, 1);
    chk("rst count", 32'(ifq_count), 32'd0);
    chk("rst valid", 32'(inst_valid), 32'd0);
    chk("rst rom_addr", rom_addr, 32'h0);
    drive(1, 0, 0, 1);
    chk("rst t1 inst", inst, 32'h1000_0000);
    chk("rst t1 inst_pc", inst_pc, 32'h0);
    drive(1, 0, 0, 1);
    chk("rst t2 inst_pc", inst_pc, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifq_fetch_ctrl.md
# ifq_fetch_ctrl

Instruction fetch controller and instruction queue for the Tomasulo front end. Each cycle it drives a 16-byte-aligned line address to the combinational instruction ROM and enqueues the usable 32-bit words of the returned 128-bit line into a FIFO, tagging each word with its PC. It presents one instruction per cycle to dispatch over a valid/ready handshake. It accepts redirects from branch/jump resolution, which flush the queue and restart fetch at the new PC.

## Interface
- DEPTH, 8, queue entries; power of 2, ≥ 4
- RESET_PC, 32'h0000_0000, PC loaded at reset

- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous reset, active-low
- rom_addr  out  32  line address to ROM = {pc[31:4], 4'b0000}; combinational from the PC register
- rom_data  in  128  line from ROM; word k at bits [32k+31:32k] = instruction at rom_addr+4k; valid in the same cycle
- redirect_valid  in  1  flush and restart request
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored, forced to 0
- inst_valid  out  1  head of queue is valid
- inst  out  32  instruction at queue head
- inst_pc  out  32  PC of `inst`
- inst_ready  in  1  dispatch consumes the head when inst_valid is also high
- ifq_count  out  clog2(DEPTH)+1  current occupancy (registered)

## Operation
- State:
  - pc register, 32 bits, bits [1:0] always 0.
  - Circular queue of {inst, pc} entries.
  - Read and write pointers, each clog2(DEPTH) bits, wrapping modulo DEPTH.
  - count register.
- Fetch width: n = 4 − pc[3:2] words, the words from index pc[3:2] through 3 of the current line.
- Fetch condition: no redirect_valid, and (DEPTH − count) ≥ n, where count is the value at the start of the cycle. A pop in the same cycle does not create space until the next cycle.
- On fetch:
  - Write words pc[3:2]..3 to consecutive entries from the write pointer, in ascending address order, tagged with PCs {pc[31:4], k, 2'b00}.
  - Set pc ← {pc[31:4] + 1, 4'b0000}.
- If the fetch condition is not met, pc holds and rom_addr is unchanged.
- Pop: occurs when inst_valid && inst_ready. The read pointer advances by 1.
- Count update: count_next = count + (words written) − (pop).
- Redirect has the highest priority:
  - Set pc ← {redirect_pc[31:2], 2'b00}.
  - Reset both pointers, set count ← 0.
  - No fetch and no pop this cycle.
- inst_valid = (count ≠ 0) && !redirect_valid.
- inst and inst_pc = entry at the read pointer. They are don't-care when inst_valid = 0.
- Reset (rst_n = 0 at a clock edge):
  - pc ← RESET_PC with bits [1:0] cleared.
  - Pointers ← 0, count ← 0.
  - Takes priority over redirect, fetch and pop, including in mid-operation.
- Reset values:
  - inst_valid = 0, ifq_count = 0.
  - rom_addr = {RESET_PC[31:4], 4'b0}.
  - inst and inst_pc are undefined.
- PC wraps from 0xFFFF_FFF0 to 0x0000_0000. This is not an error.
- No internal overflow or underflow is possible given the rules above. The verification engineer asserts count ≤ DEPTH every cycle.

## Timing
- ROM is read combinationally: rom_addr comes from the pc flop and rom_data is captured at the next rising edge.
- Fetch-to-dispatch latency:
  - A word fetched in cycle t is visible as inst_valid in cycle t+1 if it is at the head.
  - First instruction after reset release: rst_n high in cycle 0 gives a fetch in cycle 0 and inst_valid = 1 in cycle 1.
- Redirect in cycle t:
  - Cycle t+1: fetch from the new line, inst_valid = 0.
  - Cycle t+2: first new instruction valid.
- Sustained throughput: up to 4 words per cycle enqueued, 1 per cycle dequeued. With DEPTH = 8 and inst_ready held high, dispatch never starves after the first cycle.
- Simultaneous pop and fetch: both take effect, and occupancy changes by n − 1.
- Simultaneous redirect and inst_ready: no pop is recorded and the head is discarded.

## Test plan
- **Streaming:** RESET_PC = 0, ROM word i = 0x1000_0000 + i, inst_ready = 1 continuously. Required: cycle 1 shows inst = 0x1000_0000, inst_pc = 0. Each following cycle increments both by 1 and 4 respectively, with no gaps, duplicates or reorder for 40 instructions.
- **Backpressure:** inst_ready = 0 from reset, DEPTH = 8. Required: ifq_count goes 0 → 4 → 8 and holds. rom_addr holds at 0x20. On release, 8 instructions 0x1000_0000..0x1000_0007 appear in order, then 0x1000_0008 follows.
- **Space threshold:** aligned pc, count = 6, inst_ready = 1. Required: no fetch while count > 4, pops take it 6 → 5 → 4, fetch occurs in the cycle count = 4 is observed, and count becomes 7 the next cycle.
- **Unaligned redirect:** redirect_pc = 0x3B, queue non-empty. Required:
  - inst_valid = 0 during the redirect cycle.
  - Next cycle: rom_addr = 0x30 and 2 words are enqueued, with PCs 0x38 and 0x3C.
  - Then rom_addr = 0x40.
  - The first dispatched instruction has inst_pc = 0x38.
- **Redirect with full queue and inst_ready = 1:** Required: count = 0 the next cycle, no pop is counted, and the old entries never reappear.
- **Reset mid-stream:** rst_n = 0 for 1 cycle with count = 5 and pc = 0x80. Required: ifq_count = 0, inst_valid = 0 and rom_addr = RESET_PC line the following cycle. Streaming restarts from RESET_PC.
